// File: rtl/pool_out_pkg.sv
// Shared types and constants for the maxpool output packing sequencer.
package pool_out_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] CODE_IDLE = 4'd0;
    localparam logic [3:0] CODE_L64  = 4'd6;
    localparam logic [3:0] CODE_L48  = 4'd8;

    localparam int W_BIG   = 64;
    localparam int W_SMALL = 48;
    localparam int CAP     = 128;
    localparam int WORD    = 64;
    localparam int OCC_W   = 8;

endpackage

// File: rtl/pool_occ_tracker.sv
// Packer occupancy in bits: loads add the beat width, each drained DRAM word removes 64.
module pool_occ_tracker #(
    parameter int CAP   = 128,
    parameter int WORD  = 64,
    parameter int OCC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             flush,
    input  logic             drain_en,
    input  logic             hs,
    input  logic [OCC_W-1:0] w,
    input  logic             dram_ready,
    output logic [OCC_W-1:0] occ,
    output logic             drain,
    output logic             room
);

    localparam logic [OCC_W:0] WORD_X = (OCC_W+1)'(WORD);
    localparam logic [OCC_W:0] CAP_X  = (OCC_W+1)'(CAP);

    logic [OCC_W:0] after_drain;

    assign drain       = drain_en && ({1'b0, occ} >= WORD_X) && dram_ready;
    // Capacity is judged after this cycle's drain so a full packer can still load while emitting.
    assign after_drain = {1'b0, occ} - (drain ? WORD_X : '0);
    assign room        = (after_drain + {1'b0, w}) <= CAP_X;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else if (clear || flush) begin
            occ <= '0;
        end else begin
            occ <= OCC_W'(after_drain + (hs ? {1'b0, w} : '0));
        end
    end

endmodule

// File: rtl/pool_out_ctrl.sv
// Layer sequencer: accepts pooled beats, drives packer load/clear/flush and DRAM word writes.
module pool_out_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int CFG_W   = 8,
    parameter int CAP     = pool_out_pkg::CAP,
    parameter int W_BIG   = pool_out_pkg::W_BIG,
    parameter int W_SMALL = pool_out_pkg::W_SMALL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_mode,
    input  logic [CFG_W-1:0]  cfg_beats,
    input  logic [CFG_W-1:0]  cfg_tiles,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              pool_valid,
    output logic              pool_ready,
    input  logic              dram_ready,
    output logic [3:0]        pkt_code,
    output logic              pkt_clear,
    output logic              pkt_flush,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    import pool_out_pkg::*;

    state_t              state, state_n;
    logic                mode_q;
    logic [CFG_W-1:0]    beats_q, tiles_q, beat_cnt, tile_cnt;
    logic [ADDR_W-1:0]   addr;
    logic [OCC_W-1:0]    occ, w;
    logic                drain, room, hs;
    logic                occ_clear, flush, drain_en, tile_end;
    logic                last_beat, last_tile, beats_left;

    assign w          = mode_q ? OCC_W'(W_SMALL) : OCC_W'(W_BIG);
    assign hs         = pool_valid && pool_ready;
    assign beats_left = beat_cnt < beats_q;
    assign last_beat  = (beat_cnt + CFG_W'(1)) == beats_q;
    assign last_tile  = (tile_cnt + CFG_W'(1)) == tiles_q;
    assign busy       = state != IDLE;

    pool_occ_tracker #(
        .CAP   (CAP),
        .WORD  (WORD),
        .OCC_W (OCC_W)
    ) u_occ (
        .clk        (clk),
        .rst        (rst),
        .clear      (occ_clear),
        .flush      (flush),
        .drain_en   (drain_en),
        .hs         (hs),
        .w          (w),
        .dram_ready (dram_ready),
        .occ        (occ),
        .drain      (drain),
        .room       (room)
    );

    always_comb begin
        state_n    = state;
        pool_ready = 1'b0;
        pkt_clear  = 1'b0;
        done       = 1'b0;
        occ_clear  = 1'b0;
        flush      = 1'b0;
        drain_en   = 1'b0;
        tile_end   = 1'b0;
        case (state)
            IDLE: if (start) state_n = CLR;
            CLR: begin
                pkt_clear = 1'b1;
                occ_clear = 1'b1;
                state_n   = (beats_q == '0 || tiles_q == '0) ? DONE : RUN;
            end
            RUN: begin
                drain_en   = 1'b1;
                pool_ready = beats_left && room;
                if (pool_valid && beats_left && room && last_beat) state_n = FLUSH;
            end
            FLUSH: begin
                drain_en = 1'b1;
                // Full words drain first; only a sub-word residue goes out as a padded flush.
                if (occ < OCC_W'(WORD)) begin
                    if (occ == '0) begin
                        tile_end = 1'b1;
                    end else if (dram_ready) begin
                        flush    = 1'b1;
                        tile_end = 1'b1;
                    end
                end
                if (tile_end) state_n = last_tile ? DONE : RUN;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            beats_q   <= '0;
            tiles_q   <= '0;
            beat_cnt  <= '0;
            tile_cnt  <= '0;
            addr      <= '0;
            pkt_code  <= CODE_IDLE;
            pkt_flush <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
        end else begin
            state     <= state_n;
            pkt_code  <= hs ? (mode_q ? CODE_L48 : CODE_L64) : CODE_IDLE;
            pkt_flush <= flush;
            wr_en     <= drain || flush;
            if (drain || flush) begin
                wr_addr <= addr;
                addr    <= addr + ADDR_W'(1);
            end
            if (state == IDLE && start) begin
                mode_q  <= cfg_mode;
                beats_q <= cfg_beats;
                tiles_q <= cfg_tiles;
                addr    <= cfg_base;
            end
            if (state == CLR) begin
                beat_cnt <= '0;
                tile_cnt <= '0;
            end
            if (hs) beat_cnt <= beat_cnt + CFG_W'(1);
            if (tile_end && !last_tile) begin
                beat_cnt <= '0;
                tile_cnt <= tile_cnt + CFG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pool_out_ctrl.sv
// Directed bench for pool_out_ctrl: counts packer/DRAM events and checks them per scenario.
module tb_pool_out_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, cfg_mode, pool_valid, dram_ready;
    logic [7:0] cfg_beats, cfg_tiles;
    logic [9:0] cfg_base;
    logic       pool_ready, pkt_clear, pkt_flush, wr_en, busy, done;
    logic [3:0] pkt_code;
    logic [9:0] wr_addr;

    int checks = 0;
    int errors = 0;

    int n_wr = 0, n_c64 = 0, n_c48 = 0, n_cbad = 0, n_fl = 0, n_done = 0, n_clr = 0, n_hs = 0;
    int s_wr, s_c64, s_c48, s_cbad, s_fl, s_done, s_clr, s_hs, s_q;
    logic [9:0] addrs[$];

    always #5 clk = ~clk;

    pool_out_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_mode   (cfg_mode),
        .cfg_beats  (cfg_beats),
        .cfg_tiles  (cfg_tiles),
        .cfg_base   (cfg_base),
        .pool_valid (pool_valid),
        .pool_ready (pool_ready),
        .dram_ready (dram_ready),
        .pkt_code   (pkt_code),
        .pkt_clear  (pkt_clear),
        .pkt_flush  (pkt_flush),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .done       (done)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                n_wr++;
                addrs.push_back(wr_addr);
            end
            if (pkt_code == 4'd6) n_c64++;
            if (pkt_code == 4'd8) n_c48++;
            if (pkt_code != 4'd0 && pkt_code != 4'd6 && pkt_code != 4'd8) n_cbad++;
            if (pkt_flush) n_fl++;
            if (done) n_done++;
            if (pkt_clear) n_clr++;
            if (pool_valid && pool_ready) n_hs++;
        end
    end

    task automatic snap();
        s_wr = n_wr; s_c64 = n_c64; s_c48 = n_c48; s_cbad = n_cbad;
        s_fl = n_fl; s_done = n_done; s_clr = n_clr; s_hs = n_hs; s_q = addrs.size();
    endtask

    task automatic kick(input logic m, input logic [7:0] b, input logic [7:0] t,
                        input logic [9:0] base, input logic dr);
        @(posedge clk); #1;
        snap();
        cfg_mode = m; cfg_beats = b; cfg_tiles = t; cfg_base = base;
        dram_ready = dr; pool_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        pool_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_beats = '0; cfg_tiles = '0;
        cfg_base = '0; pool_valid = 1'b0; dram_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pool_ready, pkt_clear, pkt_flush, wr_en, busy, done, pkt_code, wr_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b clr=%b fl=%b wr=%b busy=%b done=%b code=%0d addr=%0d, expected all 0",
                     pool_ready, pkt_clear, pkt_flush, wr_en, busy, done, pkt_code, wr_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mode0_basic();
        bit got;
        kick(1'b0, 8'd4, 8'd1, 10'd10, 1'b1);
        wait_done(got);
        checks++; if (!got) begin errors++; $display("FAIL m0_done_seen: no done within bound"); end
        checks++; if (n_c64 - s_c64 !== 4) begin errors++; $display("FAIL m0_code64: got %0d expected 4", n_c64 - s_c64); end
        checks++; if (n_wr - s_wr !== 4) begin errors++; $display("FAIL m0_writes: got %0d expected 4", n_wr - s_wr); end
        checks++; if (n_fl - s_fl !== 0) begin errors++; $display("FAIL m0_flush: got %0d expected 0", n_fl - s_fl); end
        checks++; if (n_done - s_done !== 1) begin errors++; $display("FAIL m0_done_cnt: got %0d expected 1", n_done - s_done); end
        checks++; if (n_clr - s_clr !== 1) begin errors++; $display("FAIL m0_clear_cnt: got %0d expected 1", n_clr - s_clr); end
        for (int i = 0; i < 4 && s_q + i < addrs.size(); i++) begin
            checks++;
            if (addrs[s_q+i] !== 10'(10 + i)) begin
                errors++; $display("FAIL m0_addr%0d: got %0d expected %0d", i, addrs[s_q+i], 10 + i);
            end
        end
    endtask

    task automatic test_mode1_aligned();
        bit got;
        kick(1'b1, 8'd4, 8'd1, 10'd100, 1'b1);
        wait_done(got);
        checks++; if (!got) begin errors++; $display("FAIL m1a_done_seen: no done within bound"); end
        checks++; if (n_c48 - s_c48 !== 4) begin errors++; $display("FAIL m1a_code48: got %0d expected 4", n_c48 - s_c48); end
        checks++; if (n_wr - s_wr !== 3) begin errors++; $display("FAIL m1a_writes: got %0d expected 3", n_wr - s_wr); end
        checks++; if (n_fl - s_fl !== 0) begin errors++; $display("FAIL m1a_flush: got %0d expected 0", n_fl - s_fl); end
        for (int i = 0; i < 3 && s_q + i < addrs.size(); i++) begin
            checks++;
            if (addrs[s_q+i] !== 10'(100 + i)) begin
                errors++; $display("FAIL m1a_addr%0d: got %0d expected %0d", i, addrs[s_q+i], 100 + i);
            end
        end
    endtask

    task automatic test_mode1_residual();
        bit got;
        kick(1'b1, 8'd3, 8'd1, 10'd200, 1'b1);
        wait_done(got);
        checks++; if (!got) begin errors++; $display("FAIL m1r_done_seen: no done within bound"); end
        checks++; if (n_c48 - s_c48 !== 3) begin errors++; $display("FAIL m1r_code48: got %0d expected 3", n_c48 - s_c48); end
        checks++; if (n_wr - s_wr !== 3) begin errors++; $display("FAIL m1r_writes: got %0d expected 3", n_wr - s_wr); end
        checks++; if (n_fl - s_fl !== 1) begin errors++; $display("FAIL m1r_flush: got %0d expected 1", n_fl - s_fl); end
        checks++; if (n_cbad - s_cbad !== 0) begin errors++; $display("FAIL m1r_badcode: got %0d expected 0", n_cbad - s_cbad); end
    endtask

    task automatic test_backpressure();
        bit got;
        kick(1'b0, 8'd4, 8'd1, 10'd300, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (n_hs - s_hs !== 2) begin errors++; $display("FAIL bp_stalled_beats: got %0d expected 2", n_hs - s_hs); end
        checks++; if (pool_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", pool_ready); end
        checks++; if (n_wr - s_wr !== 0) begin errors++; $display("FAIL bp_no_write: got %0d expected 0", n_wr - s_wr); end
        dram_ready = 1'b1;
        wait_done(got);
        checks++; if (!got) begin errors++; $display("FAIL bp_done_seen: no done within bound"); end
        checks++; if (n_hs - s_hs !== 4) begin errors++; $display("FAIL bp_beats: got %0d expected 4", n_hs - s_hs); end
        checks++; if (n_wr - s_wr !== 4) begin errors++; $display("FAIL bp_writes: got %0d expected 4", n_wr - s_wr); end
        for (int i = 0; i < 4 && s_q + i < addrs.size(); i++) begin
            checks++;
            if (addrs[s_q+i] !== 10'(300 + i)) begin
                errors++; $display("FAIL bp_addr%0d: got %0d expected %0d", i, addrs[s_q+i], 300 + i);
            end
        end
    endtask

    task automatic test_multi_tile();
        bit got;
        kick(1'b1, 8'd3, 8'd2, 10'd400, 1'b1);
        wait_done(got);
        checks++; if (!got) begin errors++; $display("FAIL mt_done_seen: no done within bound"); end
        checks++; if (n_wr - s_wr !== 6) begin errors++; $display("FAIL mt_writes: got %0d expected 6", n_wr - s_wr); end
        checks++; if (n_fl - s_fl !== 2) begin errors++; $display("FAIL mt_flush: got %0d expected 2", n_fl - s_fl); end
        checks++; if (n_c48 - s_c48 !== 6) begin errors++; $display("FAIL mt_code48: got %0d expected 6", n_c48 - s_c48); end
        checks++; if (n_done - s_done !== 1) begin errors++; $display("FAIL mt_done_cnt: got %0d expected 1", n_done - s_done); end
        for (int i = 0; i < 6 && s_q + i < addrs.size(); i++) begin
            checks++;
            if (addrs[s_q+i] !== 10'(400 + i)) begin
                errors++; $display("FAIL mt_addr%0d: got %0d expected %0d", i, addrs[s_q+i], 400 + i);
            end
        end
    endtask

    task automatic test_wrap();
        bit got;
        logic [9:0] exp [4];
        exp[0] = 10'd1022; exp[1] = 10'd1023; exp[2] = 10'd0; exp[3] = 10'd1;
        kick(1'b0, 8'd4, 8'd1, 10'd1022, 1'b1);
        wait_done(got);
        checks++; if (n_wr - s_wr !== 4) begin errors++; $display("FAIL wrap_writes: got %0d expected 4", n_wr - s_wr); end
        for (int i = 0; i < 4 && s_q + i < addrs.size(); i++) begin
            checks++;
            if (addrs[s_q+i] !== exp[i]) begin
                errors++; $display("FAIL wrap_addr%0d: got %0d expected %0d", i, addrs[s_q+i], exp[i]);
            end
        end
    endtask

    task automatic test_zero_tiles();
        bit got;
        kick(1'b0, 8'd4, 8'd0, 10'd500, 1'b1);
        wait_done(got);
        checks++; if (!got) begin errors++; $display("FAIL zt_done_seen: no done within bound"); end
        checks++; if (n_clr - s_clr !== 1) begin errors++; $display("FAIL zt_clear: got %0d expected 1", n_clr - s_clr); end
        checks++; if (n_wr - s_wr !== 0) begin errors++; $display("FAIL zt_writes: got %0d expected 0", n_wr - s_wr); end
        checks++; if (n_hs - s_hs !== 0) begin errors++; $display("FAIL zt_beats: got %0d expected 0", n_hs - s_hs); end
    endtask

    task automatic test_reset_mid();
        kick(1'b0, 8'd8, 8'd1, 10'd600, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before: got %b expected 1", busy); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({pool_ready, pkt_clear, pkt_flush, wr_en, busy, done, pkt_code, wr_addr} !== '0) begin
            errors++;
            $display("FAIL rm_outputs: got rdy=%b clr=%b fl=%b wr=%b busy=%b done=%b code=%0d addr=%0d, expected all 0",
                     pool_ready, pkt_clear, pkt_flush, wr_en, busy, done, pkt_code, wr_addr);
        end
        rst = 1'b0;
        pool_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (n_done - s_done !== 0) begin errors++; $display("FAIL rm_no_done: got %0d expected 0", n_done - s_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle: got busy=%b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_mode1_aligned();
        test_mode1_residual();
        test_backpressure();
        test_multi_tile();
        test_wrap();
        test_zero_tiles();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
